// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default pointer width, pointer type and Gray-code helpers.
// The helpers work on a wide vector so any pointer width up to PW_MAX fits; callers
// zero-extend their pointer into the argument and cast the result back to their width.
package async_fifo_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned PW_MAX = 16;

   typedef logic [ADDR_W:0] ptr_t;

   function automatic logic [PW_MAX-1:0] bin2gray(input logic [PW_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW_MAX-1:0] gray2bin(input logic [PW_MAX-1:0] g);
      logic [PW_MAX-1:0] b;
      b[PW_MAX-1] = g[PW_MAX-1];
      for (int unsigned i = PW_MAX - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// Plain multi-stage flop chain for bringing a Gray pointer across clock domains.
// No logic between stages; shared by the read and write sides.
module ptr_sync #(
   parameter int unsigned W      = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic         rclk,
   input  logic         rd_srst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain [STAGES];

   // shift the asynchronous pointer through the synchroniser stages
   always_ff @(posedge rclk) begin
      if (rd_srst) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/rd_pointer.sv
// Read-side pointer, empty flag and fill level for the async FIFO (read clock domain).
// Optional macro RD_PTR_ALMOST_EMPTY_EN adds the registered almost_empty output.
module rd_pointer #(
   parameter int unsigned ADDR_W    = async_fifo_pkg::ADDR_W,
   parameter int unsigned SYNC_STG  = 2,
   parameter int unsigned AE_THRESH = 1
) (
   input  logic              rclk,
   input  logic              rd_srst,
   input  logic              rd_en,
   input  logic [ADDR_W:0]   wr_ptr_gray,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic              rd_ack,
   output logic              empty,
   output logic [ADDR_W:0]   rd_level
`ifdef RD_PTR_ALMOST_EMPTY_EN
   ,
   output logic              almost_empty
`endif
);

   import async_fifo_pkg::*;

   localparam int unsigned PW = ADDR_W + 1;

   logic [ADDR_W:0] rd_ptr_bin;
   logic [ADDR_W:0] wq_gray;
   logic [ADDR_W:0] wq_bin;
   logic [ADDR_W:0] rbin_nxt;
   logic [ADDR_W:0] rgray_nxt;
   logic [ADDR_W:0] level_nxt;

   ptr_sync #(
      .W      (PW),
      .STAGES (SYNC_STG)
   ) u_wptr_sync (
      .rclk    (rclk),
      .rd_srst (rd_srst),
      .d       (wr_ptr_gray),
      .q       (wq_gray)
   );

   // accept logic, next pointer values and the level seen after this cycle's read
   always_comb begin
      rd_ack    = rd_en & ~empty & ~rd_srst;
      wq_bin    = PW'(gray2bin(PW_MAX'(wq_gray)));
      rbin_nxt  = rd_ptr_bin + PW'(rd_ack);
      rgray_nxt = PW'(bin2gray(PW_MAX'(rbin_nxt)));
      level_nxt = wq_bin - rbin_nxt;
   end

   // pointer, Gray pointer and status registers
   always_ff @(posedge rclk) begin
      if (rd_srst) begin
         rd_ptr_bin  <= '0;
         rd_ptr_gray <= '0;
         empty       <= 1'b1;
         rd_level    <= '0;
      end else begin
         rd_ptr_bin  <= rbin_nxt;
         rd_ptr_gray <= rgray_nxt;
         empty       <= (rgray_nxt == wq_gray);
         rd_level    <= level_nxt;
      end
   end

`ifdef RD_PTR_ALMOST_EMPTY_EN
   // registered almost-empty flag from the same next-state level
   always_ff @(posedge rclk) begin
      if (rd_srst) begin
         almost_empty <= 1'b1;
      end else begin
         almost_empty <= (32'(level_nxt) <= AE_THRESH);
      end
   end
`endif

   assign rd_addr = rd_ptr_bin[ADDR_W-1:0];

endmodule
